// File: rtl/time_sync_pkg.sv
// Shared time-sync definitions: packet layout, ToD struct and master FSM encodings.
// Also used by the time-sync slave, so field offsets must stay in lockstep with it.
package time_sync_pkg;

  localparam logic [15:0] SYNC_MAGIC     = 16'h77f8;
  localparam int          SYNC_PKT_WIDTH = 144;
  localparam int          SYNC_MAGIC_LSB = 0;
  localparam int          SYNC_DST_LSB   = 16;
  localparam int          SYNC_SRC_LSB   = 32;
  localparam int          SYNC_TS_LSB    = 48;
  localparam logic [31:0] NS_PER_SEC     = 32'd1_000_000_000;

  typedef struct packed {
    logic [47:0] sec;
    logic [31:0] ns;
    logic [15:0] frac;
  } ptp_tod_t;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_SEND    = 2'd2;

  function automatic logic [SYNC_PKT_WIDTH-1:0] build_sync_pkt(
    input logic [15:0] dst,
    input logic [15:0] src,
    input ptp_tod_t    ts
  );
    logic [SYNC_PKT_WIDTH-1:0] pkt;
    pkt                      = '0;
    pkt[SYNC_MAGIC_LSB +: 16] = SYNC_MAGIC;
    pkt[SYNC_DST_LSB +: 16]   = dst;
    pkt[SYNC_SRC_LSB +: 16]   = src;
    pkt[SYNC_TS_LSB +: 96]    = ts;
    return pkt;
  endfunction

endpackage

// File: rtl/ptp_ts96_add_ns.sv
// Combinational 96-bit ToD plus nanoseconds, carrying into the 48-bit seconds field.
// Fractional nanoseconds pass through untouched.
module ptp_ts96_add_ns
  import time_sync_pkg::*;
(
  input  ptp_tod_t    ts_in,
  input  logic [31:0] add_ns,
  output ptp_tod_t    ts_out
);

  logic [32:0] ns_sum;

  // Sum is kept 33 bits wide so an out-of-range ns input cannot silently wrap.
  always_comb begin
    ns_sum = {1'b0, ts_in.ns} + {1'b0, add_ns};
    ts_out = ts_in;
    if (ns_sum >= {1'b0, NS_PER_SEC}) begin
      ts_out.ns  = 32'(ns_sum - {1'b0, NS_PER_SEC});
      ts_out.sec = ts_in.sec + 48'd1;
    end else begin
      ts_out.ns = ns_sum[31:0];
    end
  end

endmodule

// File: rtl/time_sync_master.sv
// Time-sync master: samples the local ToD on a period tick or trigger, compensates it,
// and streams a 144-bit sync packet out over AXIS.
module time_sync_master
  import time_sync_pkg::*;
#(
  parameter int IDENTIFIER_WIDTH   = 16,
  parameter int AXIS_DATA_WIDTH    = 64,
  parameter int AXIS_KEEP_WIDTH    = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_TX_ID_WIDTH   = 8,
  parameter int AXIS_TX_DEST_WIDTH = 8,
  parameter int AXIS_TX_USER_WIDTH = 1,
  parameter int TX_DEST            = 0,
  parameter int SELF_ID            = 123456,
  parameter int TS_COMP_NS         = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [31:0]                   period_cycles,
  input  logic                          trigger,
  input  logic [IDENTIFIER_WIDTH-1:0]   dst_id,
  input  logic [95:0]                   ptp_ts_96,
  output logic [AXIS_DATA_WIDTH-1:0]    m_axis_sync_tx_data,
  output logic [AXIS_KEEP_WIDTH-1:0]    m_axis_sync_tx_keep,
  output logic                          m_axis_sync_tx_valid,
  input  logic                          m_axis_sync_tx_ready,
  output logic                          m_axis_sync_tx_last,
  output logic [AXIS_TX_ID_WIDTH-1:0]   m_axis_sync_tx_id,
  output logic [AXIS_TX_DEST_WIDTH-1:0] m_axis_sync_tx_dest,
  output logic [AXIS_TX_USER_WIDTH-1:0] m_axis_sync_tx_user,
  output logic [31:0]                   sent_count,
  output logic [15:0]                   drop_count
);

  localparam int NB         = (SYNC_PKT_WIDTH + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
  localparam int PAD_WIDTH  = NB * AXIS_DATA_WIDTH;
  localparam int PKT_BYTES  = SYNC_PKT_WIDTH / 8;
  localparam int LAST_BYTES = (PKT_BYTES % AXIS_KEEP_WIDTH == 0) ? AXIS_KEEP_WIDTH
                                                                 : PKT_BYTES % AXIS_KEEP_WIDTH;
  localparam logic [AXIS_KEEP_WIDTH-1:0]  FULL_KEEP = '1;
  localparam logic [AXIS_KEEP_WIDTH-1:0]  LAST_KEEP = FULL_KEEP >> (AXIS_KEEP_WIDTH - LAST_BYTES);
  localparam logic [1:0]                  LAST_BEAT = 2'(NB - 1);
  localparam logic [IDENTIFIER_WIDTH-1:0] SRC_ID    = IDENTIFIER_WIDTH'(SELF_ID);

  logic [31:0]          period_cnt;
  logic                 tick, request, pending, consume, handshake;
  logic [1:0]           state, beat;
  logic [PAD_WIDTH-1:0] sreg, pkt_pad;
  ptp_tod_t             tod_in, tod_comp;

  assign tod_in    = ptp_tod_t'(ptp_ts_96);
  assign tick      = enable && (period_cycles != 32'd0) && (period_cnt == 32'd0);
  assign request   = tick || (trigger && enable);
  assign consume   = (state == ST_IDLE) && pending;
  assign handshake = m_axis_sync_tx_valid && m_axis_sync_tx_ready;

  assign m_axis_sync_tx_id   = '0;
  assign m_axis_sync_tx_dest = AXIS_TX_DEST_WIDTH'(TX_DEST);
  assign m_axis_sync_tx_user = '0;

  ptp_ts96_add_ns u_ts_add (
    .ts_in  (tod_in),
    .add_ns (32'(TS_COMP_NS)),
    .ts_out (tod_comp)
  );

  assign pkt_pad = PAD_WIDTH'(build_sync_pkt(dst_id, SRC_ID, tod_comp));

  // While disabled the counter sits at its reload value, so re-enabling restarts a full period.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      period_cnt <= period_cycles - 32'd1;
    end else if (period_cycles != 32'd0) begin
      period_cnt <= (period_cnt == 32'd0) ? period_cycles - 32'd1 : period_cnt - 32'd1;
    end
  end

  // A request arriving in the cycle the old one is consumed refills the slot instead of dropping.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= 1'b0;
      drop_count <= 16'd0;
    end else begin
      pending <= enable && (request || (pending && !consume));
      if (request && pending && !consume && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= ST_IDLE;
      beat                 <= 2'd0;
      sreg                 <= '0;
      m_axis_sync_tx_data  <= '0;
      m_axis_sync_tx_keep  <= '0;
      m_axis_sync_tx_valid <= 1'b0;
      m_axis_sync_tx_last  <= 1'b0;
      sent_count           <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          m_axis_sync_tx_data  <= pkt_pad[AXIS_DATA_WIDTH-1:0];
          sreg                 <= pkt_pad >> AXIS_DATA_WIDTH;
          m_axis_sync_tx_keep  <= (NB == 1) ? LAST_KEEP : FULL_KEEP;
          m_axis_sync_tx_last  <= (NB == 1);
          m_axis_sync_tx_valid <= 1'b1;
          beat                 <= 2'd0;
          state                <= ST_SEND;
        end
        ST_SEND: begin
          if (handshake) begin
            if (beat == LAST_BEAT) begin
              m_axis_sync_tx_data  <= '0;
              m_axis_sync_tx_keep  <= '0;
              m_axis_sync_tx_valid <= 1'b0;
              m_axis_sync_tx_last  <= 1'b0;
              sent_count           <= sent_count + 32'd1;
              state                <= ST_IDLE;
            end else begin
              m_axis_sync_tx_data <= sreg[AXIS_DATA_WIDTH-1:0];
              sreg                <= sreg >> AXIS_DATA_WIDTH;
              beat                <= beat + 2'd1;
              m_axis_sync_tx_last <= (beat + 2'd1 == LAST_BEAT);
              m_axis_sync_tx_keep <= (beat + 2'd1 == LAST_BEAT) ? LAST_KEEP : FULL_KEEP;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_sync_master.sv
// Self-checking bench for time_sync_master (64-bit AXIS, 500 ns compensation) against a
// reference model that rebuilds packets from absolute nanosecond arithmetic.
module tb_time_sync_master;

  localparam int              DW      = 64;
  localparam int              KW      = 8;
  localparam int              COMP_NS = 500;
  localparam int              SELF    = 123456;
  localparam longint unsigned NS_SEC  = 64'd1_000_000_000;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, trigger = 1'b0, ready = 1'b1;
  logic [31:0] period_cycles = 32'd0;
  logic [15:0] dst_id = 16'd0;
  logic [95:0] ptp_ts_96 = 96'd0;

  logic [DW-1:0] tx_data;
  logic [KW-1:0] tx_keep;
  logic          tx_valid, tx_last;
  logic [7:0]    tx_id, tx_dest;
  logic [0:0]    tx_user;
  logic [31:0]   sent_count;
  logic [15:0]   drop_count;

  int cyc = 0;
  int n_vec = 0, n_err = 0;

  logic [DW-1:0] mon_data[$];
  logic [KW-1:0] mon_keep[$];
  logic          mon_last[$];
  int            mon_cyc[$];

  time_sync_master #(
    .AXIS_DATA_WIDTH (DW),
    .SELF_ID         (SELF),
    .TS_COMP_NS      (COMP_NS)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable               (enable),
    .period_cycles        (period_cycles),
    .trigger              (trigger),
    .dst_id               (dst_id),
    .ptp_ts_96            (ptp_ts_96),
    .m_axis_sync_tx_data  (tx_data),
    .m_axis_sync_tx_keep  (tx_keep),
    .m_axis_sync_tx_valid (tx_valid),
    .m_axis_sync_tx_ready (ready),
    .m_axis_sync_tx_last  (tx_last),
    .m_axis_sync_tx_id    (tx_id),
    .m_axis_sync_tx_dest  (tx_dest),
    .m_axis_sync_tx_user  (tx_user),
    .sent_count           (sent_count),
    .drop_count           (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted beat, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && tx_valid && ready) begin
      mon_data.push_back(tx_data);
      mon_keep.push_back(tx_keep);
      mon_last.push_back(tx_last);
      mon_cyc.push_back(cyc);
    end
  end

  function automatic logic [191:0] model_pkt(input logic [15:0] dst, input logic [95:0] tod);
    longint unsigned t;
    logic [191:0]    p;
    t          = 64'(tod[95:48]) * NS_SEC + 64'(tod[47:16]) + 64'(COMP_NS);
    p          = '0;
    p[15:0]    = 16'h77f8;
    p[31:16]   = dst;
    p[47:32]   = 16'(SELF);
    p[63:48]   = tod[15:0];
    p[95:64]   = 32'(t % NS_SEC);
    p[143:96]  = 48'(t / NS_SEC);
    return p;
  endfunction

  function automatic logic [191:0] frame_at(input int i);
    return {mon_data[i+2], mon_data[i+1], mon_data[i]};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_data.delete(); mon_keep.delete(); mon_last.delete(); mon_cyc.delete();
  endtask

  task automatic fire(output int n);
    trigger = 1'b1;
    n = cyc;
    step(1);
    trigger = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %b want 0", tx_valid); end
    n_vec++; if (tx_last !== 1'b0) begin n_err++; $display("[TB] FAIL reset_last: got %b want 0", tx_last); end
    n_vec++; if (tx_data !== 64'd0) begin n_err++; $display("[TB] FAIL reset_data: got %h want 0", tx_data); end
    n_vec++; if (tx_keep !== 8'd0) begin n_err++; $display("[TB] FAIL reset_keep: got %h want 0", tx_keep); end
    n_vec++; if (sent_count !== 32'd0) begin n_err++; $display("[TB] FAIL reset_sent: got %0d want 0", sent_count); end
    n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("[TB] FAIL reset_drop: got %0d want 0", drop_count); end
    n_vec++; if ({tx_id, tx_dest, tx_user} !== 17'd0) begin n_err++; $display("[TB] FAIL reset_sideband: got %h want 0", {tx_id, tx_dest, tx_user}); end
    rst = 1'b0;
    enable = 1'b1;
    step(2);
  endtask

  task automatic test_single_trigger();
    int n;
    logic [191:0] exp;
    clear_mon();
    ptp_ts_96 = {48'd5, 32'd100, 16'd0};
    dst_id = 16'h1234;
    exp = model_pkt(dst_id, ptp_ts_96);
    fire(n);
    step(10);
    n_vec++; if (mon_data.size() !== 3) begin n_err++; $display("[TB] FAIL single_beats: got %0d want 3", mon_data.size()); end
    if (mon_data.size() == 3) begin
      n_vec++; if (mon_cyc[0] !== n + 3) begin n_err++; $display("[TB] FAIL single_latency: got %0d want %0d", mon_cyc[0], n + 3); end
      n_vec++; if (mon_data[0][15:0] !== 16'h77f8) begin n_err++; $display("[TB] FAIL single_magic: got %h want 77f8", mon_data[0][15:0]); end
      n_vec++; if ({mon_keep[0], mon_keep[1]} !== 16'hFFFF) begin n_err++; $display("[TB] FAIL single_keep01: got %h want ffff", {mon_keep[0], mon_keep[1]}); end
      n_vec++; if (mon_keep[2] !== 8'h03) begin n_err++; $display("[TB] FAIL single_keep2: got %h want 03", mon_keep[2]); end
      n_vec++; if ({mon_last[0], mon_last[1], mon_last[2]} !== 3'b001) begin n_err++; $display("[TB] FAIL single_last: got %b want 001", {mon_last[0], mon_last[1], mon_last[2]}); end
      n_vec++; if (frame_at(0) !== exp) begin n_err++; $display("[TB] FAIL single_frame: got %h want %h", frame_at(0), exp); end
    end
    n_vec++; if (sent_count !== 32'd1) begin n_err++; $display("[TB] FAIL single_sent: got %0d want 1", sent_count); end
  endtask

  task automatic test_ts_carry();
    int n;
    logic [191:0] f;
    clear_mon();
    ptp_ts_96 = {48'd7, 32'd999_999_800, 16'hABCD};
    dst_id = 16'h0042;
    fire(n);
    step(10);
    n_vec++; if (mon_data.size() !== 3) begin n_err++; $display("[TB] FAIL carry_beats: got %0d want 3", mon_data.size()); end
    if (mon_data.size() == 3) begin
      f = frame_at(0);
      n_vec++; if (f[143:96] !== 48'd8) begin n_err++; $display("[TB] FAIL carry_sec: got %0d want 8", f[143:96]); end
      n_vec++; if (f[95:64] !== 32'd300) begin n_err++; $display("[TB] FAIL carry_ns: got %0d want 300", f[95:64]); end
      n_vec++; if (f[63:48] !== 16'hABCD) begin n_err++; $display("[TB] FAIL carry_frac: got %h want abcd", f[63:48]); end
    end
    n_vec++; if (sent_count !== 32'd2) begin n_err++; $display("[TB] FAIL carry_sent: got %0d want 2", sent_count); end
  endtask

  // ToD changes every cycle, so the frame must carry the value seen two cycles after the trigger.
  task automatic test_random_ts();
    int n;
    logic [95:0]  sampled;
    logic [191:0] exp;
    for (int r = 0; r < 8; r++) begin
      clear_mon();
      dst_id  = 16'($urandom);
      n       = cyc;
      sampled = '0;
      for (int k = 0; k < 12; k++) begin
        ptp_ts_96 = {16'd0, 32'($urandom), 32'($urandom_range(999_999_999, 0)), 16'($urandom)};
        if (k == 2) sampled = ptp_ts_96;
        trigger = (k == 0);
        step(1);
      end
      trigger = 1'b0;
      exp = model_pkt(dst_id, sampled);
      n_vec++; if (mon_data.size() !== 3) begin n_err++; $display("[TB] FAIL rand_beats[%0d]: got %0d want 3", r, mon_data.size()); end
      if (mon_data.size() == 3) begin
        n_vec++; if (mon_cyc[0] !== n + 3) begin n_err++; $display("[TB] FAIL rand_latency[%0d]: got %0d want %0d", r, mon_cyc[0], n + 3); end
        n_vec++; if (frame_at(0) !== exp) begin n_err++; $display("[TB] FAIL rand_frame[%0d]: got %h want %h", r, frame_at(0), exp); end
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [191:0] exp;
    clear_mon();
    ptp_ts_96 = {48'h0000_1234_5678, 32'd123_456_789, 16'h5A5A};
    dst_id = 16'hBEEF;
    exp = model_pkt(dst_id, ptp_ts_96);
    fire(n);
    step(3);
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if ({tx_valid, tx_last, tx_keep, tx_data} !== {1'b1, 1'b0, 8'hFF, exp[127:64]}) begin
        n_err++;
        $display("[TB] FAIL stall_hold[%0d]: got v%b l%b k%h d%h want v1 l0 kff d%h", k, tx_valid, tx_last, tx_keep, tx_data, exp[127:64]);
      end
      step(1);
    end
    ready = 1'b1;
    step(6);
    n_vec++; if (mon_data.size() !== 3) begin n_err++; $display("[TB] FAIL stall_beats: got %0d want 3", mon_data.size()); end
    if (mon_data.size() == 3) begin
      n_vec++; if (frame_at(0) !== exp) begin n_err++; $display("[TB] FAIL stall_frame: got %h want %h", frame_at(0), exp); end
      n_vec++; if (mon_cyc[1] !== n + 9) begin n_err++; $display("[TB] FAIL stall_beat1_cycle: got %0d want %0d", mon_cyc[1], n + 9); end
    end
  endtask

  task automatic test_back_to_back();
    int n, d0, s0;
    logic [191:0] exp;
    clear_mon();
    ptp_ts_96 = {48'd42, 32'd1_000, 16'h0001};
    dst_id = 16'h0007;
    exp = model_pkt(dst_id, ptp_ts_96);
    d0 = drop_count;
    s0 = sent_count;
    trigger = 1'b1;
    n = cyc;
    step(3);
    trigger = 1'b0;
    step(12);
    n_vec++; if (mon_data.size() !== 6) begin n_err++; $display("[TB] FAIL b2b_beats: got %0d want 6", mon_data.size()); end
    if (mon_data.size() == 6) begin
      n_vec++; if (mon_cyc[0] !== n + 3) begin n_err++; $display("[TB] FAIL b2b_first: got %0d want %0d", mon_cyc[0], n + 3); end
      n_vec++; if (mon_cyc[3] !== n + 8) begin n_err++; $display("[TB] FAIL b2b_second: got %0d want %0d", mon_cyc[3], n + 8); end
      n_vec++; if (frame_at(3) !== exp) begin n_err++; $display("[TB] FAIL b2b_frame: got %h want %h", frame_at(3), exp); end
    end
    n_vec++; if (int'(drop_count) - d0 !== 1) begin n_err++; $display("[TB] FAIL b2b_drop: got %0d want 1", int'(drop_count) - d0); end
    n_vec++; if (int'(sent_count) - s0 !== 2) begin n_err++; $display("[TB] FAIL b2b_sent: got %0d want 2", int'(sent_count) - s0); end
  endtask

  task automatic test_disabled();
    int n, d0;
    clear_mon();
    enable = 1'b0;
    d0 = drop_count;
    fire(n);
    step(10);
    n_vec++; if (mon_data.size() !== 0) begin n_err++; $display("[TB] FAIL dis_beats: got %0d want 0", mon_data.size()); end
    n_vec++; if (int'(drop_count) !== d0) begin n_err++; $display("[TB] FAIL dis_drop: got %0d want %0d", drop_count, d0); end
    enable = 1'b1;
    step(1);
  endtask

  task automatic test_periodic();
    int e, d0;
    enable = 1'b0;
    period_cycles = 32'd100;
    step(2);
    clear_mon();
    d0 = drop_count;
    enable = 1'b1;
    e = cyc;
    step(1010);
    enable = 1'b0;
    period_cycles = 32'd0;
    step(2);
    enable = 1'b1;
    n_vec++; if (mon_data.size() !== 30) begin n_err++; $display("[TB] FAIL per_beats: got %0d want 30", mon_data.size()); end
    if (mon_data.size() == 30) begin
      n_vec++; if (mon_cyc[0] !== e + 102) begin n_err++; $display("[TB] FAIL per_first: got %0d want %0d", mon_cyc[0], e + 102); end
      for (int k = 1; k < 10; k++) begin
        n_vec++;
        if (mon_cyc[3*k] - mon_cyc[3*k-3] !== 100) begin
          n_err++; $display("[TB] FAIL per_spacing[%0d]: got %0d want 100", k, mon_cyc[3*k] - mon_cyc[3*k-3]);
        end
      end
    end
    n_vec++; if (int'(drop_count) !== d0) begin n_err++; $display("[TB] FAIL per_drop: got %0d want %0d", drop_count, d0); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [191:0] exp;
    clear_mon();
    ptp_ts_96 = {48'd99, 32'd999_999_999, 16'hFFFF};
    dst_id = 16'h0BAD;
    exp = model_pkt(dst_id, ptp_ts_96);
    fire(n);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_vec++; if ({tx_valid, tx_last} !== 2'b00) begin n_err++; $display("[TB] FAIL rstmid_valid: got %b want 00", {tx_valid, tx_last}); end
    n_vec++; if (sent_count !== 32'd0) begin n_err++; $display("[TB] FAIL rstmid_sent: got %0d want 0", sent_count); end
    n_vec++; if (drop_count !== 16'd0) begin n_err++; $display("[TB] FAIL rstmid_drop: got %0d want 0", drop_count); end
    step(4);
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_resume: got %b want 0", tx_valid); end
    clear_mon();
    fire(n);
    step(10);
    n_vec++; if (mon_data.size() !== 3) begin n_err++; $display("[TB] FAIL rstmid_beats: got %0d want 3", mon_data.size()); end
    if (mon_data.size() == 3) begin
      n_vec++; if (mon_cyc[0] !== n + 3) begin n_err++; $display("[TB] FAIL rstmid_latency: got %0d want %0d", mon_cyc[0], n + 3); end
      n_vec++; if (frame_at(0) !== exp) begin n_err++; $display("[TB] FAIL rstmid_frame: got %h want %h", frame_at(0), exp); end
    end
    n_vec++; if (sent_count !== 32'd1) begin n_err++; $display("[TB] FAIL rstmid_sent_after: got %0d want 1", sent_count); end
  endtask

  initial begin
    test_reset();
    test_single_trigger();
    test_ts_carry();
    test_random_ts();
    test_backpressure();
    test_back_to_back();
    test_disabled();
    test_periodic();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
